// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter (CPU port 0, DMA/debug port 1) with bounded locked bursts.
// Latency: grant and memory drive are combinational; read data returns registered one cycle after a read grant.
// Backpressure: a losing requester simply sees gnt low and must hold its request; build with DMEM_ARB_STATS_EN for grant counters.
module dmem_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_LOCK = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic          lock0,
    input  logic          lock1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    input  logic [3:0]    we0,
    input  logic [3:0]    we1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic [3:0]    mem_we,
    input  logic [DW-1:0] mem_rdata,
    output logic [15:0]   stat_gnt0,
    output logic [15:0]   stat_gnt1
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } own_t;

    localparam logic [8:0] MAX_LOCK_W = 9'(MAX_LOCK);

    own_t       own_q, own_d;
    logic       prio_q, prio_d;
    logic [7:0] lock_cnt_q, lock_cnt_d;
    logic [8:0] run_nxt;
    logic       gnt_lock;

    // Unsupported write codes (6, 9..15) degrade to a plain read.
    function automatic logic [3:0] eff_we(input logic [3:0] we);
        case (we)
            4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd7, 4'd8: eff_we = we;
            default:                                   eff_we = 4'd0;
        endcase
    endfunction

    // Grant selection: a requesting owner keeps the bus, otherwise single requester or round-robin tie-break.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (own_q == OWN0 && req0) begin
            gnt0 = 1'b1;
        end else if (own_q == OWN1 && req1) begin
            gnt1 = 1'b1;
        end else if (req0 && req1) begin
            if (prio_q) gnt1 = 1'b1;
            else        gnt0 = 1'b1;
        end else if (req0) begin
            gnt0 = 1'b1;
        end else if (req1) begin
            gnt1 = 1'b1;
        end
    end

    // Memory drive: winner's request goes out; idle bus parks on port 0 with writes disabled.
    always_comb begin
        mem_addr  = addr0;
        mem_wdata = wdata0;
        mem_we    = 4'd0;
        if (gnt1) begin
            mem_addr  = addr1;
            mem_wdata = wdata1;
            mem_we    = eff_we(we1);
        end else if (gnt0) begin
            mem_we    = eff_we(we0);
        end
    end

    // Ownership next-state: extend a locked burst until MAX_LOCK consecutive grants, then hand priority over.
    always_comb begin
        own_d      = IDLE;
        lock_cnt_d = 8'd0;
        prio_d     = prio_q;
        run_nxt    = 9'd1;
        gnt_lock   = gnt0 ? lock0 : lock1;
        if (gnt0 || gnt1) begin
            // The run only continues when the same port that owned the bus wins again.
            if ((gnt0 && own_q == OWN0) || (gnt1 && own_q == OWN1)) begin
                run_nxt = {1'b0, lock_cnt_q} + 9'd1;
            end
            if (gnt_lock && run_nxt < MAX_LOCK_W) begin
                own_d      = gnt0 ? OWN0 : OWN1;
                lock_cnt_d = run_nxt[7:0];
            end else begin
                prio_d = gnt0;
            end
        end
    end

    // Arbitration state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            own_q      <= IDLE;
            prio_q     <= 1'b0;
            lock_cnt_q <= 8'd0;
        end else begin
            own_q      <= own_d;
            prio_q     <= prio_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

    // Read return: capture memory data for a granted read and pulse that port's rvalid.
    always_ff @(posedge clk) begin
        if (reset) begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            rdata0  <= '0;
            rdata1  <= '0;
        end else begin
            rvalid0 <= gnt0 && (mem_we == 4'd0);
            rvalid1 <= gnt1 && (mem_we == 4'd0);
            if (gnt0 && mem_we == 4'd0) rdata0 <= mem_rdata;
            if (gnt1 && mem_we == 4'd0) rdata1 <= mem_rdata;
        end
    end

`ifdef DMEM_ARB_STATS_EN
    // Saturating per-port grant counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_gnt0 <= 16'h0000;
            stat_gnt1 <= 16'h0000;
        end else begin
            if (gnt0 && stat_gnt0 != 16'hFFFF) stat_gnt0 <= stat_gnt0 + 16'd1;
            if (gnt1 && stat_gnt1 != 16'hFFFF) stat_gnt1 <= stat_gnt1 + 16'd1;
        end
    end
`else
    assign stat_gnt0 = 16'h0000;
    assign stat_gnt1 = 16'h0000;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomised and directed bench for dmem_arbiter against a behavioural arbitration/memory model.
// Latency: one model step per clock; combinational outputs checked mid-cycle, registered ones after the edge.
// Backpressure: stimulus holds a losing requester's req/addr/wdata/we until it is granted.
module tb_dmem_arbiter;

    localparam int AW       = 32;
    localparam int DW       = 32;
    localparam int MAX_LOCK = 3;

    logic          clk;
    logic          reset;
    logic          req0, req1, lock0, lock1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic [3:0]    we0, we1;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata0, rdata1;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [3:0]    mem_we;
    logic [DW-1:0] mem_rdata;
    logic [15:0]   stat_gnt0, stat_gnt1;

    dmem_arbiter #(.AW(AW), .DW(DW), .MAX_LOCK(MAX_LOCK)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .we0(we0), .we1(we1), .gnt0(gnt0), .gnt1(gnt1),
        .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata0(rdata0), .rdata1(rdata1),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .stat_gnt0(stat_gnt0), .stat_gnt1(stat_gnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Byte-lane write semantics of the data memory.
    function automatic logic [31:0] wr_merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] code);
        logic [31:0] m;
        case (code)
            4'd1: m = 32'h0000_00FF;
            4'd2: m = 32'h0000_FF00;
            4'd3: m = 32'h00FF_0000;
            4'd4: m = 32'hFF00_0000;
            4'd5: m = 32'h0000_FFFF;
            4'd7: m = 32'hFFFF_0000;
            4'd8: m = 32'hFFFF_FFFF;
            default: m = 32'h0;
        endcase
        return (old & ~m) | (wd & m);
    endfunction

    function automatic logic [31:0] seed(input int i);
        return 32'hC0DE_0000 | (i * 32'h0000_0101);
    endfunction

    // Bench-side memory, driven only by the DUT's memory port.
    logic [31:0] mem [64];
    bit          mem_ready;
    assign mem_rdata = mem[mem_addr[7:2]];
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 64; i++) mem[i] <= seed(i);
            mem_ready <= 1'b1;
        end else if (mem_we != 4'd0) begin
            mem[mem_addr[7:2]] <= wr_merge(mem[mem_addr[7:2]], mem_wdata, mem_we);
        end
    end

    // Reference model state.
    logic [31:0] ref_mem [64];
    int          m_owner;          // -1: nobody holds a lock
    int          m_run;            // consecutive locked grants of the owner
    int          m_prio;
    bit          exp_rvalid [2];
    logic [31:0] exp_rdata [2];
    int          exp_stat [2];
    bit          last_gnt [2];

    function automatic bit is_write(input logic [3:0] w);
        return w inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd7, 4'd8};
    endfunction

    // One clock of stimulus: check the combinational decision, advance the model, check registered outputs.
    task automatic cycle(input bit rst);
        bit          rq [2];
        bit          lk [2];
        logic [31:0] ad [2];
        logic [31:0] wd [2];
        logic [3:0]  wc [2];
        int          win;
        logic [3:0]  ew;
        int          run;
        rq = '{req0, req1}; lk = '{lock0, lock1};
        ad = '{addr0, addr1}; wd = '{wdata0, wdata1}; wc = '{we0, we1};
        reset = rst;
        #1;
        if (m_owner >= 0 && rq[m_owner]) win = m_owner;
        else if (rq[0] && rq[1])          win = m_prio;
        else if (rq[0])                   win = 0;
        else if (rq[1])                   win = 1;
        else                              win = -1;
        ew = (win >= 0 && is_write(wc[win])) ? wc[win] : 4'd0;
        chk("gnt", {gnt1, gnt0}, {62'd0, win == 1, win == 0});
        chk("mem_we", mem_we, ew);
        chk("mem_addr", mem_addr, (win == 1) ? ad[1] : ad[0]);
        chk("mem_wdata", mem_wdata, (win == 1) ? wd[1] : wd[0]);
        exp_rvalid[0] = 1'b0;
        exp_rvalid[1] = 1'b0;
        last_gnt[0] = (win == 0);
        last_gnt[1] = (win == 1);
        if (win < 0) begin
            m_owner = -1;
            m_run   = 0;
        end else begin
            if (ew == 4'd0) begin
                exp_rvalid[win] = 1'b1;
                exp_rdata[win]  = ref_mem[ad[win][7:2]];
            end else begin
                ref_mem[ad[win][7:2]] = wr_merge(ref_mem[ad[win][7:2]], wd[win], ew);
            end
`ifdef DMEM_ARB_STATS_EN
            if (exp_stat[win] < 65535) exp_stat[win]++;
`endif
            run = (m_owner == win) ? m_run + 1 : 1;
            if (lk[win] && run < MAX_LOCK) begin
                m_owner = win;
                m_run   = run;
            end else begin
                m_owner = -1;
                m_run   = 0;
                m_prio  = 1 - win;
            end
        end
        if (rst) begin
            m_owner = -1; m_run = 0; m_prio = 0;
            exp_rvalid = '{1'b0, 1'b0};
            exp_rdata  = '{32'h0, 32'h0};
            exp_stat   = '{0, 0};
        end
        @(posedge clk);
        #1;
        chk("rvalid0", rvalid0, exp_rvalid[0]);
        chk("rvalid1", rvalid1, exp_rvalid[1]);
        chk("rdata0", rdata0, exp_rdata[0]);
        chk("rdata1", rdata1, exp_rdata[1]);
        chk("stat_gnt0", stat_gnt0, exp_stat[0]);
        chk("stat_gnt1", stat_gnt1, exp_stat[1]);
    endtask

    task automatic set_port(input int p, input bit r, input bit l, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] w);
        if (p == 0) begin req0 = r; lock0 = l; addr0 = a; wdata0 = d; we0 = w; end
        else        begin req1 = r; lock1 = l; addr1 = a; wdata1 = d; we1 = w; end
    endtask

    task automatic idle_ports();
        set_port(0, 0, 0, 32'h0, 32'h0, 4'd0);
        set_port(1, 0, 0, 32'h0, 32'h0, 4'd0);
    endtask

    // New random request for a port unless it is still waiting for a grant.
    task automatic rand_port(input int p);
        bit waiting;
        logic [3:0] w;
        waiting = (p == 0) ? (req0 && !last_gnt[0]) : (req1 && !last_gnt[1]);
        if (waiting) begin
            if (p == 0) lock0 = $urandom_range(0, 1);
            else        lock1 = $urandom_range(0, 1);
        end else begin
            w = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            set_port(p, $urandom_range(0, 99) < 70, $urandom_range(0, 1),
                     32'($urandom_range(0, 255)), $urandom, w);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) ref_mem[i] = seed(i);
        m_owner = -1; m_run = 0; m_prio = 0;
        exp_rvalid = '{1'b0, 1'b0};
        exp_rdata  = '{32'h0, 32'h0};
        exp_stat   = '{0, 0};
        last_gnt   = '{1'b0, 1'b0};
        reset = 1'b1;
        idle_ports();
        @(posedge clk);
        #1;
        cycle(1'b1);
        cycle(1'b1);

        // Single port-0 read of 0x04.
        set_port(0, 1, 0, 32'h04, 32'h0, 4'd0);
        cycle(1'b0);
        idle_ports();
        cycle(1'b0);

        // Both ports read without lock: grants alternate from prio 0.
        cycle(1'b1);
        set_port(0, 1, 0, 32'h20, 32'h0, 4'd0);
        set_port(1, 1, 0, 32'h24, 32'h0, 4'd0);
        repeat (4) cycle(1'b0);
        idle_ports();

        // Port-1 full-word write then port-0 read back.
        set_port(1, 1, 0, 32'h10, 32'hDEAD_BEEF, 4'd8);
        cycle(1'b0);
        idle_ports();
        set_port(0, 1, 0, 32'h10, 32'h0, 4'd0);
        cycle(1'b0);
        idle_ports();
        cycle(1'b0);
        chk("readback", rdata0, 32'hDEAD_BEEF);

        // Locked port-0 burst against a waiting port 1.
        set_port(0, 1, 1, 32'h30, 32'h0, 4'd0);
        set_port(1, 1, 0, 32'h34, 32'h0, 4'd0);
        repeat (3) cycle(1'b0);
        cycle(1'b0);
        idle_ports();
        cycle(1'b0);

        // Unsupported write codes act as reads.
        set_port(0, 1, 0, 32'h40, 32'h1234_5678, 4'd6);
        cycle(1'b0);
        set_port(0, 1, 0, 32'h44, 32'h1234_5678, 4'd12);
        cycle(1'b0);
        idle_ports();

        // Reset in the middle of a port-1 lock, then prio restarts at 0.
        set_port(1, 1, 1, 32'h50, 32'h0, 4'd0);
        cycle(1'b0);
        cycle(1'b0);
        cycle(1'b1);
        set_port(0, 1, 0, 32'h54, 32'h0, 4'd0);
        cycle(1'b0);
        idle_ports();

        // Grant counters: five port-0 then three port-1 grants after reset.
        cycle(1'b1);
        set_port(0, 1, 0, 32'h60, 32'h0, 4'd0);
        repeat (5) cycle(1'b0);
        idle_ports();
        set_port(1, 1, 0, 32'h64, 32'h0, 4'd0);
        repeat (3) cycle(1'b0);
        idle_ports();
`ifdef DMEM_ARB_STATS_EN
        chk("stat0_total", stat_gnt0, 64'd5);
        chk("stat1_total", stat_gnt1, 64'd3);
`else
        chk("stat0_total", stat_gnt0, 64'd0);
        chk("stat1_total", stat_gnt1, 64'd0);
`endif

        // Random traffic with occasional reset.
        for (int i = 0; i < 3000; i++) begin
            rand_port(0);
            rand_port(1);
            cycle($urandom_range(0, 99) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter in front of the byte-addressed data memory. Port 0 is the CPU load/store path; port 1 is the DMA/debug loader.
- Selects one requester per cycle and drives the memory's address, write-data and write-enable code.
- Registers the read data back to the winning requester.
- Supports short locked bursts with a hard ownership timeout, so neither port can starve the other.

Parameters:
- AW, 32, address width of requester and memory address buses.
- DW, 32, data width.
- MAX_LOCK, 8, maximum consecutive locked grants to one port before forced release (1..255).

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- req0 / req1  in  1  request from port 0 / port 1
- lock0 / lock1  in  1  request to keep ownership next cycle (qualified by reqN)
- addr0 / addr1  in  AW  byte address (memory word-aligns internally)
- wdata0 / wdata1  in  DW  write data
- we0 / we1  in  4  write-enable code: 0 read; 1..4 byte lane 0..3; 5 low half; 7 high half; 8 full word
- gnt0 / gnt1  out  1  combinational grant, same cycle as accepted request
- rvalid0 / rvalid1  out  1  read data valid, one cycle after a read grant
- rdata0 / rdata1  out  DW  registered read data
- mem_addr  out  AW  to memory daddr
- mem_wdata  out  DW  to memory dwdata
- mem_we  out  4  to memory we
- mem_rdata  in  DW  from memory drdata (combinational read)
- stat_gnt0 / stat_gnt1  out  16  grant counters (see Optional Feature)

Behaviour:
- State: own (IDLE, OWN0, OWN1), prio pointer (0/1), lock_cnt (8 bit).
- Reset values: own=IDLE, prio=0, lock_cnt=0, rvalid0/1=0, rdata0/1=0, stat counters=0.
- gnt0/gnt1 and mem_* are combinational from state and inputs.

Grant selection, each cycle:
- In OWNn: if reqN=1, grant port n.
- In OWNn with reqN=0: fall back to IDLE rules in the same cycle.
- In IDLE: if only one port requests, grant it. If both request, grant the port given by prio.
- At most one gnt high. No request means gnt0=gnt1=0 and mem_we=0.

Memory drive:
- Winner's addr/wdata/we go to mem_*.
- we codes 6 and 9..15 are forwarded as 0 and treated as a read.
- With no grant, mem_addr/mem_wdata hold the port-0 values and mem_we=0.

Write timing:
- A write occurs at the rising edge ending the grant cycle.
- The requester sees gnt and may change its inputs next cycle.

Read timing:
- Grant with effective code 0 gives rvalidN=1 and rdataN=mem_rdata in the following cycle.
- rvalid is a single-cycle pulse per granted read.
- rdata holds its value until the next read to that port.

Non-granted requester:
- Must hold req/addr/wdata/we stable until granted. No timeout on waiting.

Lock and ownership update, on a grant to port n:
- If lockN=1 and lock_cnt+1 < MAX_LOCK: own=OWNn, lock_cnt+=1, prio unchanged.
- Otherwise (no lock, or this is the MAX_LOCK-th consecutive grant): own=IDLE, lock_cnt=0, prio = other port.
- Consequence: with MAX_LOCK=1, lock is ignored.
- No grant this cycle: own=IDLE, lock_cnt=0, prio unchanged.

Boundaries:
- Port dropping req while owning releases ownership immediately.
- Reset asserted mid-burst returns to IDLE next edge. No rvalid is produced for a read granted in the reset cycle.
- Read and write are never granted in the same cycle.

Optional Feature:
- Macro DMEM_ARB_STATS_EN.
- Defined: stat_gnt0/stat_gnt1 are 16-bit counters. Each increments by 1 per grant to its port and saturates at 16'hFFFF. Both clear on reset.
- Undefined: no counter logic; both ports tied to 16'h0000.

Test Plan:
- Reset, then req0=1 read addr 0x04 only -> gnt0=1 same cycle; mem_we=0; next cycle rvalid0=1 and rdata0 = mem_rdata sampled at 0x04.
- Both req, no lock, 4 cycles after reset -> grants alternate 0,1,0,1; prio=0 at the end.
- req1 write we1=8 addr 0x10 wdata 0xDEADBEEF, then req0 read 0x10 -> mem_we=8 for one cycle; rdata0=0xDEADBEEF, rvalid0 one cycle after the read grant.
- MAX_LOCK=3; port0 holds req0=lock0=1 while req1=1 -> gnt0 for 3 cycles, then gnt1; req1 stalled, no rvalid1 until granted.
- we0=6 and we0=12 -> mem_we=0, treated as reads, rvalid0 pulses; reset asserted during a port1 lock -> own=IDLE, rvalid=0, next grant follows prio=0.
- With DMEM_ARB_STATS_EN defined, 5 port0 and 3 port1 grants -> stat_gnt0=5, stat_gnt1=3. Undefined -> both read 0.
